// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_arb_pkg;

   localparam int NPORT   = 4;
   localparam int ADDR_W  = 28;
   localparam int BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin pick
module rr_arbiter4 (
   input  logic [3:0] i_req,
   input  logic [1:0] i_ptr,
   output logic [1:0] o_grant,
   output logic       o_grant_valid
);

   logic [1:0] w_idx;

   // Walk offsets from farthest to nearest so the port closest to the pointer wins last
   always_comb begin
      o_grant       = 2'd0;
      o_grant_valid = 1'b0;
      w_idx         = i_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_idx = i_ptr + 2'(k);
         if (i_req[w_idx]) begin
            o_grant       = w_idx;
            o_grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin arbiter of four cache ports onto one data-memory port
module dmem_port_arbiter #(
   parameter int ADDR_W  = dmem_arb_pkg::ADDR_W,
   parameter int BLOCK_W = dmem_arb_pkg::BLOCK_W,
   parameter int NPORT   = dmem_arb_pkg::NPORT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               c0_read,
   input  logic               c0_write,
   input  logic [ADDR_W-1:0]  c0_address,
   input  logic [BLOCK_W-1:0] c0_writedata,
   output logic [BLOCK_W-1:0] c0_readdata,
   output logic               c0_busywait,
   input  logic               c1_read,
   input  logic               c1_write,
   input  logic [ADDR_W-1:0]  c1_address,
   input  logic [BLOCK_W-1:0] c1_writedata,
   output logic [BLOCK_W-1:0] c1_readdata,
   output logic               c1_busywait,
   input  logic               c2_read,
   input  logic               c2_write,
   input  logic [ADDR_W-1:0]  c2_address,
   input  logic [BLOCK_W-1:0] c2_writedata,
   output logic [BLOCK_W-1:0] c2_readdata,
   output logic               c2_busywait,
   input  logic               c3_read,
   input  logic               c3_write,
   input  logic [ADDR_W-1:0]  c3_address,
   input  logic [BLOCK_W-1:0] c3_writedata,
   output logic [BLOCK_W-1:0] c3_readdata,
   output logic               c3_busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_ready
);

   import dmem_arb_pkg::*;

   state_t             r_state;
   state_t             w_next;
   logic [1:0]         r_ptr;
   logic [1:0]         r_grant;
   op_t                r_op;
   logic [ADDR_W-1:0]  r_addr;
   logic [BLOCK_W-1:0] r_wdata;
   logic [BLOCK_W-1:0] r_rdata;

   logic [NPORT-1:0]   w_req;
   logic [NPORT-1:0]   w_wr;
   logic [1:0]         w_pick;
   logic               w_pick_valid;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [BLOCK_W-1:0] w_sel_wdata;
   logic               w_release;

   assign w_wr  = {c3_write, c2_write, c1_write, c0_write};
   assign w_req = w_wr | {c3_read, c2_read, c1_read, c0_read};

   rr_arbiter4 u_rr (
      .i_req         (w_req),
      .i_ptr         (r_ptr),
      .o_grant       (w_pick),
      .o_grant_valid (w_pick_valid)
   );

   // Route the winning port's address and write block toward the latch registers
   always_comb begin
      w_sel_addr  = c0_address;
      w_sel_wdata = c0_writedata;
      case (w_pick)
         2'd1: begin w_sel_addr = c1_address; w_sel_wdata = c1_writedata; end
         2'd2: begin w_sel_addr = c2_address; w_sel_wdata = c2_writedata; end
         2'd3: begin w_sel_addr = c3_address; w_sel_wdata = c3_writedata; end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state: grant when anyone asks, wait for memory, then one release cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_next = BUSY;
         BUSY:    if (mem_ready)    w_next = RELEASE;
         RELEASE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Latch the granted request, capture fill data, advance the pointer past the served port
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr   <= 2'd0;
         r_grant <= 2'd0;
         r_op    <= OP_READ;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_pick_valid) begin
               r_grant <= w_pick;
               r_op    <= w_wr[w_pick] ? OP_WRITE : OP_READ;
               r_addr  <= w_sel_addr;
               r_wdata <= w_sel_wdata;
            end
            BUSY: if (mem_ready && (r_op == OP_READ)) r_rdata <= mem_readdata;
            RELEASE: r_ptr <= r_grant + 2'd1;
            default: ;
         endcase
      end
   end

   assign w_release     = (r_state == RELEASE);
   assign mem_read      = (r_state == BUSY) && (r_op == OP_READ);
   assign mem_write     = (r_state == BUSY) && (r_op == OP_WRITE);
   assign mem_address   = r_addr;
   assign mem_writedata = r_wdata;

   assign c0_readdata = r_rdata;
   assign c1_readdata = r_rdata;
   assign c2_readdata = r_rdata;
   assign c3_readdata = r_rdata;

   assign c0_busywait = w_req[0] && !(w_release && (r_grant == 2'd0));
   assign c1_busywait = w_req[1] && !(w_release && (r_grant == 2'd1));
   assign c2_busywait = w_req[2] && !(w_release && (r_grant == 2'd2));
   assign c3_busywait = w_req[3] && !(w_release && (r_grant == 2'd3));

endmodule
